wb_sdram_master: RTL and testbench
==================================

WB_SDRAM_MASTER -- requirements
Module: wb_sdram_master

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max cycles waiting for sdram_ack before abort.
REQ-002 Parameter ADDR_W, default 32, meaning request/bus address width.
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  client access request.
REQ-006 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  word address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_sel  input  4  byte enables.
REQ-011 rsp_valid  output  1  one-cycle pulse, access finished.
REQ-012 rsp_rdata  output  32  read data, valid with rsp_valid on reads; holds last value otherwise.
REQ-013 rsp_err  output  1  with rsp_valid, timeout abort.
REQ-014 cyc_i, stb_i, we_i  output  1 each  Wishbone cycle, strobe, write enable.
REQ-015 sel_i  output  4; addr_i  output  ADDR_W; data_i  output  32  Wishbone select, address, write data.
REQ-016 data_o  input  32; stall_o  input  1; sdram_ack  input  1  Wishbone read data, stall, acknowledge.

Function
REQ-017 FSM states: IDLE, CYC, STB, ACK, REL.
REQ-018 IDLE: on handshake latch we/addr/wdata/sel into holding registers, go to CYC; else stay.
REQ-019 CYC: cyc_i=1, stb_i=0 for exactly one cycle, then STB.
REQ-020 STB: cyc_i=1, stb_i=1; when stall_o=0 go to ACK; while stall_o=1 stay.
REQ-021 ACK: cyc_i=1, stb_i=1 held until sdram_ack sampled 1, then REL.
REQ-022 ACK with sdram_ack: read captures data_o into rsp_rdata same edge.
REQ-023 REL: cyc_i=0, stb_i=0, rsp_valid=1 for one cycle, then IDLE; guarantees slave sees cyc drop between accesses.
REQ-024 we_i, sel_i, addr_i, data_i driven from holding registers throughout CYC..ACK, stable, zero in IDLE.
REQ-025 Timeout counter clears on entry to CYC, increments each cycle in STB/ACK; reaching TIMEOUT-1 forces REL with rsp_err=1, rsp_rdata unchanged.
REQ-026 sdram_ack outside ACK state ignored.
REQ-027 Single outstanding access; no pipelining; req_valid outside IDLE ignored.
REQ-028 Minimum latency handshake-to-rsp_valid with zero stall, ack same cycle as STB exit: 4 cycles.

Reset
REQ-029 rst_n low asynchronously forces IDLE, all outputs 0, req_ready=1 once rst_n high, holding registers and counter 0.
REQ-030 Reset mid-access drops cyc_i/stb_i immediately; no rsp_valid issued for aborted access.

Structure
REQ-031 Shared package holds FSM state encodings (4-bit, matching existing bus state width) and default TIMEOUT.
REQ-032 Timeout counter is natural sub-module wb_timeout_cnt (clear, enable, terminal flag).

Verification
REQ-033 Write 0xDEADBEEF to addr 5, slave acks after 4 STB cycles -> we_i=1, addr_i=5, data_i=0xDEADBEEF held until ack, rsp_valid one pulse, rsp_err=0.
REQ-034 Read addr 5 after REQ-033 -> rsp_rdata=0xDEADBEEF with rsp_valid, cyc_i low one cycle before req_ready.
REQ-035 stall_o=1 for 3 cycles in STB -> stb_i held, state stays STB, completes normally after release.
REQ-036 No ack, TIMEOUT=8 -> rsp_valid with rsp_err=1 exactly 8 cycles after CYC entry, rsp_rdata unchanged.
REQ-037 rst_n pulsed low during ACK -> cyc_i/stb_i 0 asynchronously, no rsp_valid, next request completes correctly.
REQ-038 Back-to-back requests with req_valid held -> second accepted only after REL, cyc_i low between accesses.

Source files
------------

// File: rtl/wb_sdram_master_pkg.sv
// wb_sdram_master_pkg: shared FSM state encoding and default abort timeout
package wb_sdram_master_pkg;
   // 4-bit encoding keeps the state register as wide as the existing bus state field
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_CYC  = 4'd1,
      ST_STB  = 4'd2,
      ST_ACK  = 4'd3,
      ST_REL  = 4'd4
   } state_t;
   localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/wb_sdram_master_timeout_cnt.sv
// wb_timeout_cnt: cycle counter that flags the cycle in which it would reach LIMIT-1
// Ports: i_clk, i_rst_n (async, active-low), i_clr (synchronous clear),
//        i_en (count this cycle), o_term (count reaches LIMIT-1 at the coming edge)
module wb_timeout_cnt
   import wb_sdram_master_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_nxt;
   assign w_nxt = r_cnt + 1'b1;
   // flagged one cycle early so the owner can leave exactly when the count lands on LIMIT-1
   assign o_term = i_en && (w_nxt == W'(LIMIT - 1));
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= w_nxt;
endmodule

// File: rtl/wb_sdram_master.sv
// wb_sdram_master: single-outstanding client request to Wishbone master bridge with ack timeout
// Ports: i_clk, i_rst_n (async, active-low)
//        client: i_req_valid/o_req_ready/i_req_we/i_req_addr/i_req_wdata/i_req_sel,
//                o_rsp_valid/o_rsp_rdata/o_rsp_err
//        bus:    o_cyc_i/o_stb_i/o_we_i/o_sel_i/o_addr_i/o_data_i, i_data_o/i_stall_o/i_sdram_ack
module wb_sdram_master
   import wb_sdram_master_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int ADDR_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   input  logic [3:0]        i_req_sel,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_cyc_i,
   output logic              o_stb_i,
   output logic              o_we_i,
   output logic [3:0]        o_sel_i,
   output logic [ADDR_W-1:0] o_addr_i,
   output logic [31:0]       o_data_i,
   input  logic [31:0]       i_data_o,
   input  logic              i_stall_o,
   input  logic              i_sdram_ack
);
   state_t            r_state, w_next;
   logic              r_we, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_rdata;
   logic [3:0]        r_sel;
   logic              w_hs, w_term, w_set_err, w_cnt_en;
   assign w_hs        = i_req_valid && o_req_ready;
   assign w_cnt_en    = (r_state == ST_STB) || (r_state == ST_ACK);
   // ready is withheld while reset is asserted
   assign o_req_ready = (r_state == ST_IDLE) && i_rst_n;
   assign o_rsp_rdata = r_rdata;
   assign o_we_i      = o_cyc_i && r_we;
   assign o_sel_i     = o_cyc_i ? r_sel : '0;
   assign o_addr_i    = o_cyc_i ? r_addr : '0;
   assign o_data_i    = o_cyc_i ? r_wdata : '0;
   wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_to (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_hs),
      .i_en    (w_cnt_en),
      .o_term  (w_term)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= ST_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next      = r_state;
      w_set_err   = 1'b0;
      o_cyc_i     = 1'b0;
      o_stb_i     = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_err   = 1'b0;
      case (r_state)
         ST_IDLE: w_next = i_req_valid ? ST_CYC : ST_IDLE;
         ST_CYC: begin
            o_cyc_i = 1'b1;
            w_next  = ST_STB;
         end
         ST_STB: begin
            o_cyc_i   = 1'b1;
            o_stb_i   = 1'b1;
            w_set_err = w_term;
            w_next    = w_term ? ST_REL : (i_stall_o ? ST_STB : ST_ACK);
         end
         ST_ACK: begin
            o_cyc_i   = 1'b1;
            o_stb_i   = 1'b1;
            // an ack in the terminal cycle still completes the access normally
            w_set_err = w_term && !i_sdram_ack;
            w_next    = (i_sdram_ack || w_term) ? ST_REL : ST_ACK;
         end
         ST_REL: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = r_err;
            w_next      = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_hs) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_sel   <= i_req_sel;
            r_err   <= 1'b0;
         end else if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (r_state == ST_ACK && i_sdram_ack && !r_we) r_rdata <= i_data_o;
      end
endmodule

// File: tb/tb_wb_sdram_master.sv
// tb_wb_sdram_master: table-driven and randomized checks of wb_sdram_master against a cycle-count model
module tb_wb_sdram_master;
   localparam int TO = 8;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_sel = '0;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] addr, wdat;
   logic [31:0] data_o = '0;
   logic        stall_o = 1'b0, ack = 1'b0;
   int          checks = 0, failures = 0;
   logic [31:0] mem [0:15];
   logic [31:0] last_rd = '0;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  sel;
      int          s;
      int          d;
      int          rsp;
      logic        err;
   } vec_t;
   vec_t vt [9];

   always #5 clk = ~clk;

   wb_sdram_master #(.TIMEOUT(TO), .ADDR_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_sel(req_sel),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_cyc_i(cyc), .o_stb_i(stb), .o_we_i(we), .o_sel_i(sel),
      .o_addr_i(addr), .o_data_i(wdat),
      .i_data_o(data_o), .i_stall_o(stall_o), .i_sdram_ack(ack)
   );

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   function automatic logic [127:0] outs();
      return {22'd0, req_ready, cyc, stb, we, sel, rsp_valid, rsp_err, addr, wdat, rsp_rdata};
   endfunction

   // s: cycles the slave stalls in STB; d: ACK-state cycles before ack; k counts cycles from CYC entry
   task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] sl, input int s, input int d, input int rsp, input logic err);
      logic [31:0] rd, exp_rd;
      int ak;
      ak = s + d + 2;
      rd = mem[a[3:0]];
      exp_rd = (w || err) ? last_rd : rd;
      req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = wd; req_sel = sl;
      chk({nm, "_ready"}, {127'd0, req_ready}, 128'd1);
      @(posedge clk);
      for (int k = 0; k <= rsp + 1; k++) begin
         @(negedge clk);
         chk($sformatf("%s_k%0d", nm, k), outs(),
             {22'd0, 1'(k > rsp), 1'(k < rsp), 1'(k >= 1 && k < rsp), (k < rsp) ? w : 1'b0,
              (k < rsp) ? sl : 4'd0, 1'(k == rsp), 1'(k == rsp && err),
              (k < rsp) ? a : 32'd0, (k < rsp) ? wd : 32'd0, (k >= rsp) ? exp_rd : last_rd});
         req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_sel = 4'($urandom);
         stall_o = (k < s + 1);
         ack = (k < rsp) && (k == ak || (k < s + 2 && $urandom_range(0, 1) == 1));
         data_o = (k == ak) ? rd : $urandom;
      end
      stall_o = 1'b0; ack = 1'b0;
      last_rd = exp_rd;
      if (w && !err)
         for (int b = 0; b < 4; b++) if (sl[b]) mem[a[3:0]][8*b +: 8] = wd[8*b +: 8];
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      vt[0] = '{1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 3, 0, 6, 1'b0};
      vt[1] = '{1'b0, 32'd5, 32'd0,        4'hF, 0, 0, 3, 1'b0};
      vt[2] = '{1'b0, 32'd5, 32'd0,        4'hF, 3, 1, 7, 1'b0};
      vt[3] = '{1'b1, 32'd5, 32'h11223344, 4'h5, 0, 0, 3, 1'b0};
      vt[4] = '{1'b0, 32'd5, 32'd0,        4'hF, 0, 2, 5, 1'b0};
      vt[5] = '{1'b0, 32'd5, 32'd0,        4'hF, 0, 20, 8, 1'b1};
      vt[6] = '{1'b1, 32'd6, 32'hCAFEF00D, 4'hF, 20, 0, 8, 1'b1};
      vt[7] = '{1'b0, 32'd5, 32'd0,        4'hF, 2, 3, 8, 1'b0};
      vt[8] = '{1'b0, 32'd6, 32'd0,        4'hF, 2, 4, 8, 1'b1};
      #1;
      chk("rst_outs", outs(), 128'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release", outs(), {22'd0, 1'b1, 105'd0});
      for (int i = 0; i < 9; i++)
         txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wd, vt[i].sel,
             vt[i].s, vt[i].d, vt[i].rsp, vt[i].err);
      chk("mem5_merge", {96'd0, mem[5]}, {96'd0, 32'hDE22BE44});
      req_valid = 1'b0;
      // reset asserted while the access waits in ACK
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd3; req_sel = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("mid_ack_bus", {126'd0, cyc, stb}, 128'd3);
      #1 rst_n = 1'b0;
      #1 chk("async_drop", {124'd0, cyc, stb, req_ready, rsp_valid}, 128'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("rst_hold%0d", i), {125'd0, cyc, rsp_valid, rsp_err}, 128'd0);
      end
      rst_n = 1'b1;
      last_rd = '0;
      #1 chk("after_rst", {95'd0, req_ready, rsp_rdata}, {95'd0, 1'b1, 32'd0});
      txn("post_rst", 1'b0, 32'd5, 32'd0, 4'hF, 1, 1, 5, 1'b0);
      // randomized back-to-back accesses with req_valid held between them
      for (int n = 0; n < 40; n++) begin
         logic        w;
         logic [31:0] a, wd;
         logic [3:0]  sl;
         int          s, d, ak, rsp;
         logic        err;
         w = 1'($urandom); a = 32'($urandom_range(0, 15)); wd = $urandom; sl = 4'($urandom);
         s = $urandom_range(0, 7); d = $urandom_range(0, 5);
         ak = s + d + 2;
         err = (ak > TO - 1);
         rsp = (err ? TO - 1 : ak) + 1;
         txn($sformatf("rnd%0d", n), w, a, wd, sl, s, d, rsp, err);
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("final_idle", outs(), {22'd0, 1'b1, 73'd0, last_rd});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
